// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared types, constants and helpers for the vscale memory arbiter.
package vscale_mem_arbiter_pkg;

    // Owner tag stored for each outstanding bus transaction.
    typedef enum logic {
        OWNER_IMEM = 1'b0,
        OWNER_DMEM = 1'b1
    } owner_e;

    // Up to two transactions in flight: one data phase overlapping the next address phase.
    localparam int ARB_DEPTH = 2;
    localparam int CNT_W     = 2;

    // Fetches are always full-word reads.
    localparam logic [2:0] IMEM_SIZE = 3'b010;

    localparam int STARVE_W = 4;

    // Starvation counter: cleared when fetch is idle or served, otherwise counts up to the limit and holds.
    function automatic logic [STARVE_W-1:0] starve_next(
        input logic [STARVE_W-1:0] cnt,
        input logic [STARVE_W-1:0] limit,
        input logic                imem_req,
        input logic                imem_accept
    );
        if (!imem_req || imem_accept) begin
            return '0;
        end
        if (cnt == limit) begin
            return cnt;
        end
        return cnt + STARVE_W'(1);
    endfunction

endpackage

// File: rtl/vscale_owner_fifo.sv
// Two-entry, one-bit owner FIFO that remembers which requester owns each
// outstanding bus transaction, in issue order.
module vscale_owner_fifo
    import vscale_mem_arbiter_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  owner_e           push_owner_i,
    input  logic             pop_i,
    output owner_e           head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [ARB_DEPTH-1:0] slot_q, slot_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push_ok;
    logic                 pop_ok;

    assign full_o  = (count_q == CNT_W'(ARB_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = owner_e'(slot_q[rd_ptr_q]);

    // A full FIFO refuses a push even if it pops in the same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            slot_d[wr_ptr_q] = push_owner_i;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register; reset discards every outstanding owner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vscale_mem_arbiter.sv
// Shares one memory bus port between instruction fetch (imem) and load/store
// (dmem). Requests and responses pass through combinationally; an owner FIFO
// routes in-order responses back, and a starvation counter keeps fetch moving
// under sustained load/store traffic.
module vscale_mem_arbiter
    import vscale_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  imem_req_i,
    input  logic [ADDR_WIDTH-1:0] imem_addr_i,
    output logic                  imem_accept_o,
    output logic                  imem_rvalid_o,
    output logic [DATA_WIDTH-1:0] imem_rdata_o,
    output logic                  imem_err_o,

    input  logic                  dmem_req_i,
    input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic                  dmem_wen_i,
    input  logic [2:0]            dmem_size_i,
    input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
    output logic                  dmem_accept_o,
    output logic                  dmem_rvalid_o,
    output logic [DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                  dmem_err_o,

    output logic                  bus_req_valid_o,
    input  logic                  bus_req_ready_i,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic                  bus_wen_o,
    output logic [2:0]            bus_size_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_resp_err_i,

    output logic                  proto_err_o
);

    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                proto_err_q, proto_err_d;

    logic                starve_hit;
    logic                grant_dmem;
    logic                req_valid;
    logic                accept;
    logic                resp_pop;
    logic                resp_orphan;

    owner_e              fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    owner_e              push_owner;

    // Grant and handshake: dmem wins unless fetch has been starved long enough.
    always_comb begin
        starve_hit  = (starve_q == STARVE_MAX) && imem_req_i;
        grant_dmem  = dmem_req_i && !starve_hit;
        req_valid   = (imem_req_i || dmem_req_i) && !fifo_full;
        accept      = req_valid && bus_req_ready_i;
        push_owner  = grant_dmem ? OWNER_DMEM : OWNER_IMEM;
        resp_pop    = bus_resp_valid_i && !fifo_empty;
        resp_orphan = bus_resp_valid_i && (fifo_count == '0);
    end

    vscale_owner_fifo u_owner_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (accept && rst_ni),
        .push_owner_i (push_owner),
        .pop_i        (resp_pop),
        .head_o       (fifo_head),
        .count_o      (fifo_count),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // Output mux; everything is forced low while reset is held.
    always_comb begin
        bus_req_valid_o = 1'b0;
        bus_addr_o      = '0;
        bus_wen_o       = 1'b0;
        bus_size_o      = 3'b000;
        bus_wdata_o     = '0;
        imem_accept_o   = 1'b0;
        dmem_accept_o   = 1'b0;
        imem_rvalid_o   = 1'b0;
        imem_rdata_o    = '0;
        imem_err_o      = 1'b0;
        dmem_rvalid_o   = 1'b0;
        dmem_rdata_o    = '0;
        dmem_err_o      = 1'b0;

        if (rst_ni) begin
            bus_req_valid_o = req_valid;
            if (grant_dmem) begin
                bus_addr_o  = dmem_addr_i;
                bus_wen_o   = dmem_wen_i;
                bus_size_o  = dmem_size_i;
                bus_wdata_o = dmem_wdata_i;
            end else begin
                bus_addr_o  = imem_addr_i;
                bus_wen_o   = 1'b0;
                bus_size_o  = IMEM_SIZE;
                bus_wdata_o = '0;
            end

            imem_accept_o = accept && !grant_dmem;
            dmem_accept_o = accept && grant_dmem;

            if (resp_pop) begin
                if (fifo_head == OWNER_IMEM) begin
                    imem_rvalid_o = 1'b1;
                    imem_rdata_o  = bus_rdata_i;
                    imem_err_o    = bus_resp_err_i;
                end else begin
                    dmem_rvalid_o = 1'b1;
                    dmem_rdata_o  = bus_rdata_i;
                    dmem_err_o    = bus_resp_err_i;
                end
            end
        end
    end

    assign proto_err_o = proto_err_q;

    // Next-state for the starvation counter and the sticky orphan-response flag.
    always_comb begin
        starve_d    = starve_next(starve_q, STARVE_MAX, imem_req_i, imem_accept_o);
        proto_err_d = proto_err_q | resp_orphan;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Self-checking bench for vscale_mem_arbiter: directed vector table,
// hand-written multi-cycle sequences, then random traffic against a
// queue-based reference model.
module tb_vscale_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    typedef struct packed {
        logic          ireq;
        logic [AW-1:0] iaddr;
        logic          dreq;
        logic [AW-1:0] daddr;
        logic          dwen;
        logic [2:0]    dsize;
        logic [DW-1:0] dwdata;
        logic          ready;
        logic          rvalid;
        logic [DW-1:0] rdata;
        logic          rerr;
    } in_t;

    typedef struct packed {
        logic          bvalid;
        logic [AW-1:0] baddr;
        logic          bwen;
        logic [2:0]    bsize;
        logic [DW-1:0] bwdata;
        logic          iacc;
        logic          dacc;
        logic          irv;
        logic          drv;
        logic [DW-1:0] rdata;
        logic          err;
        logic          perr;
    } exp_t;

    typedef struct {
        string name;
        in_t   in;
        exp_t  ex;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_accept, imem_rvalid, imem_err;
    logic [DW-1:0] imem_rdata;
    logic          dmem_req, dmem_wen;
    logic [AW-1:0] dmem_addr;
    logic [2:0]    dmem_size;
    logic [DW-1:0] dmem_wdata;
    logic          dmem_accept, dmem_rvalid, dmem_err;
    logic [DW-1:0] dmem_rdata;
    logic          bus_req_valid, bus_req_ready, bus_wen;
    logic [AW-1:0] bus_addr;
    logic [2:0]    bus_size;
    logic [DW-1:0] bus_wdata;
    logic          bus_resp_valid, bus_resp_err;
    logic [DW-1:0] bus_rdata;
    logic          proto_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: owners in flight, starvation count, sticky flag.
    bit mq[$];
    int mstarve;
    bit mperr;

    always #5 clk = ~clk;

    vscale_mem_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .imem_req_i       (imem_req),
        .imem_addr_i      (imem_addr),
        .imem_accept_o    (imem_accept),
        .imem_rvalid_o    (imem_rvalid),
        .imem_rdata_o     (imem_rdata),
        .imem_err_o       (imem_err),
        .dmem_req_i       (dmem_req),
        .dmem_addr_i      (dmem_addr),
        .dmem_wen_i       (dmem_wen),
        .dmem_size_i      (dmem_size),
        .dmem_wdata_i     (dmem_wdata),
        .dmem_accept_o    (dmem_accept),
        .dmem_rvalid_o    (dmem_rvalid),
        .dmem_rdata_o     (dmem_rdata),
        .dmem_err_o       (dmem_err),
        .bus_req_valid_o  (bus_req_valid),
        .bus_req_ready_i  (bus_req_ready),
        .bus_addr_o       (bus_addr),
        .bus_wen_o        (bus_wen),
        .bus_size_o       (bus_size),
        .bus_wdata_o      (bus_wdata),
        .bus_resp_valid_i (bus_resp_valid),
        .bus_rdata_i      (bus_rdata),
        .bus_resp_err_i   (bus_resp_err),
        .proto_err_o      (proto_err)
    );

    function automatic in_t mk_in(input logic ireq, input logic [AW-1:0] iaddr,
                                  input logic dreq, input logic [AW-1:0] daddr,
                                  input logic dwen, input logic [2:0] dsize,
                                  input logic [DW-1:0] dwdata, input logic ready,
                                  input logic rv, input logic [DW-1:0] rd, input logic re);
        in_t v;
        v.ireq = ireq;   v.iaddr = iaddr;
        v.dreq = dreq;   v.daddr = daddr;  v.dwen = dwen;  v.dsize = dsize;  v.dwdata = dwdata;
        v.ready = ready; v.rvalid = rv;    v.rdata = rd;   v.rerr = re;
        return v;
    endfunction

    function automatic exp_t mk_ex(input logic bv, input logic [AW-1:0] ba, input logic bw,
                                   input logic [2:0] bs, input logic [DW-1:0] bwd,
                                   input logic ia, input logic da, input logic irv, input logic drv,
                                   input logic [DW-1:0] rd, input logic er, input logic pe);
        exp_t e;
        e.bvalid = bv;  e.baddr = ba;  e.bwen = bw;  e.bsize = bs;  e.bwdata = bwd;
        e.iacc = ia;    e.dacc = da;   e.irv = irv;  e.drv = drv;
        e.rdata = rd;   e.err = er;    e.perr = pe;
        return e;
    endfunction

    task automatic apply(input in_t v);
        imem_req       = v.ireq;
        imem_addr      = v.iaddr;
        dmem_req       = v.dreq;
        dmem_addr      = v.daddr;
        dmem_wen       = v.dwen;
        dmem_size      = v.dsize;
        dmem_wdata     = v.dwdata;
        bus_req_ready  = v.ready;
        bus_resp_valid = v.rvalid;
        bus_rdata      = v.rdata;
        bus_resp_err   = v.rerr;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare(input string name, input exp_t e);
        chk({name, "_ctrl"},
            {bus_req_valid, imem_accept, dmem_accept, imem_rvalid, dmem_rvalid, proto_err},
            {e.bvalid, e.iacc, e.dacc, e.irv, e.drv, e.perr});
        if (e.bvalid) begin
            chk({name, "_addr"}, bus_addr, e.baddr);
            chk({name, "_wfields"}, {bus_wen, bus_size, bus_wdata}, {e.bwen, e.bsize, e.bwdata});
        end
        if (e.irv) chk({name, "_irsp"}, {imem_err, imem_rdata}, {e.err, e.rdata});
        if (e.drv) chk({name, "_drsp"}, {dmem_err, dmem_rdata}, {e.err, e.rdata});
    endtask

    // Drive one cycle's inputs, check at the falling edge, advance past the rising edge.
    task automatic step(input string name, input in_t i, input exp_t e);
        apply(i);
        @(negedge clk);
        compare(name, e);
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        mstarve = 0;
        mperr   = 1'b0;
    endtask

    // Expected outputs straight from the arbitration rules.
    function automatic exp_t model_eval(input in_t i);
        exp_t e;
        bit   lim_hit, pick_d, acc;
        e        = '0;
        lim_hit  = (mstarve == LIM) && i.ireq;
        pick_d   = i.dreq && !lim_hit;
        e.bvalid = (i.ireq || i.dreq) && (mq.size() < 2);
        acc      = e.bvalid && i.ready;
        e.iacc   = acc && !pick_d;
        e.dacc   = acc && pick_d;
        if (pick_d) begin
            e.baddr = i.daddr; e.bwen = i.dwen; e.bsize = i.dsize; e.bwdata = i.dwdata;
        end else begin
            e.baddr = i.iaddr; e.bwen = 1'b0; e.bsize = 3'b010; e.bwdata = '0;
        end
        if (i.rvalid && mq.size() > 0) begin
            if (mq[0]) e.drv = 1'b1;
            else       e.irv = 1'b1;
            e.rdata = i.rdata;
            e.err   = i.rerr;
        end
        e.perr = mperr;
        return e;
    endfunction

    task automatic model_commit(input in_t i, input exp_t e);
        if (i.rvalid) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else               mperr = 1'b1;
        end
        if (e.iacc) mq.push_back(1'b0);
        if (e.dacc) mq.push_back(1'b1);
        if (!i.ireq || e.iacc) mstarve = 0;
        else if (mstarve < LIM) mstarve++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[20];
        in_t  idle;
        in_t  cur;
        exp_t e, last_e;
        exp_t zero_ex;

        idle    = mk_in(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        zero_ex = '0;

        tbl[0]  = '{"fetch_req",   mk_in(1, 'h100, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0),
                                   mk_ex(1, 'h100, 0, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{"fetch_resp",  mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'h13, 0),
                                   mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 'h13, 0, 0)};
        tbl[2]  = '{"load_req",    mk_in(0, 0, 1, 'h200, 0, 3'b010, 0, 1, 0, 0, 0),
                                   mk_ex(1, 'h200, 0, 3'b010, 0, 0, 1, 0, 0, 0, 0, 0)};
        tbl[3]  = '{"fetch_ovl",   mk_in(1, 'h104, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0),
                                   mk_ex(1, 'h104, 0, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[4]  = '{"resp_aa",     mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'hAA, 0),
                                   mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 'hAA, 0, 0)};
        tbl[5]  = '{"resp_bb",     mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'hBB, 0),
                                   mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 'hBB, 0, 0)};
        tbl[6]  = '{"store_req",   mk_in(0, 0, 1, 'h300, 1, 3'b001, 'h55, 1, 0, 0, 0),
                                   mk_ex(1, 'h300, 1, 3'b001, 'h55, 0, 1, 0, 0, 0, 0, 0)};
        tbl[7]  = '{"store_err",   mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'h0, 1),
                                   mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 'h0, 1, 0)};
        tbl[8]  = '{"fetch_next",  mk_in(1, 'h108, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0),
                                   mk_ex(1, 'h108, 0, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{"fetch_ok",    mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'h13, 0),
                                   mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 'h13, 0, 0)};
        tbl[10] = '{"fill1",       mk_in(1, 'h10C, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0),
                                   mk_ex(1, 'h10C, 0, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[11] = '{"fill2",       mk_in(0, 0, 1, 'h400, 0, 3'b010, 0, 1, 0, 0, 0),
                                   mk_ex(1, 'h400, 0, 3'b010, 0, 0, 1, 0, 0, 0, 0, 0)};
        tbl[12] = '{"full_block",  mk_in(1, 'h110, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0),
                                   mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[13] = '{"full_pop",    mk_in(1, 'h110, 0, 0, 0, 3'b000, 0, 1, 1, 'h11, 0),
                                   mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 'h11, 0, 0)};
        tbl[14] = '{"after_pop",   mk_in(1, 'h110, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0),
                                   mk_ex(1, 'h110, 0, 3'b010, 0, 1, 0, 0, 0, 0, 0, 0)};
        tbl[15] = '{"drain1",      mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'h22, 0),
                                   mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 'h22, 0, 0)};
        tbl[16] = '{"drain2",      mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'h33, 0),
                                   mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 'h33, 0, 0)};
        tbl[17] = '{"ready_low",   mk_in(0, 0, 1, 'h500, 0, 3'b010, 'h1234, 0, 0, 0, 0),
                                   mk_ex(1, 'h500, 0, 3'b010, 'h1234, 0, 0, 0, 0, 0, 0, 0)};
        tbl[18] = '{"ready_high",  mk_in(0, 0, 1, 'h500, 0, 3'b010, 'h1234, 1, 0, 0, 0),
                                   mk_ex(1, 'h500, 0, 3'b010, 'h1234, 0, 1, 0, 0, 0, 0, 0)};
        tbl[19] = '{"drain3",      mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'h44, 0),
                                   mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 'h44, 0, 0)};

        // Reset: all outputs low even with active inputs.
        apply(idle);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        apply(mk_in(1, 'h100, 1, 'h200, 1, 3'b001, 'hFF, 1, 1, 'h77, 1));
        @(negedge clk);
        compare("reset", zero_ex);
        chk("reset_bus", {bus_addr, bus_wen, bus_size, bus_wdata[27:0]}, 64'h0);
        chk("reset_rdata", {imem_rdata, dmem_rdata}, 64'h0);
        chk("reset_err", {imem_err, dmem_err}, 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vector table.
        for (int k = 0; k < 20; k++) begin
            step(tbl[k].name, tbl[k].in, tbl[k].ex);
        end

        // Starvation: both requesting, fetch wins on the fifth cycle, then dmem again.
        for (int c = 0; c < 6; c++) begin
            apply(mk_in(1, 'h600, 1, 'h700, 0, 3'b010, 0, 1, (c > 0), 32'h1000 + c, 0));
            @(negedge clk);
            chk($sformatf("starve_acc%0d", c), {imem_accept, dmem_accept},
                (c == 4) ? 64'h2 : 64'h1);
            chk($sformatf("starve_rv%0d", c), {imem_rvalid, dmem_rvalid},
                (c == 0) ? 64'h0 : ((c == 5) ? 64'h2 : 64'h1));
            @(posedge clk);
            #1;
        end
        step("starve_drain", mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'h99, 0),
             mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 'h99, 0, 0));

        // Orphan response: dropped, flag sets and sticks.
        step("orphan", mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'h5A, 0), zero_ex);
        for (int c = 0; c < 3; c++) begin
            step($sformatf("perr_hold%0d", c), idle, mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1));
        end

        // Reset mid-transaction: outstanding fetch discarded, its late response is an orphan.
        step("pre_rst_fetch", mk_in(1, 'h800, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0),
             mk_ex(1, 'h800, 0, 3'b010, 0, 1, 0, 0, 0, 0, 0, 1));
        rst_n = 1'b0;
        apply(mk_in(1, 'h804, 1, 'h900, 0, 3'b010, 0, 1, 1, 'h66, 0));
        @(negedge clk);
        compare("mid_rst", zero_ex);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("late_resp", mk_in(0, 0, 0, 0, 0, 3'b000, 0, 1, 1, 'h66, 0), zero_ex);
        step("late_perr", idle, mk_ex(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1));

        // Random traffic against the reference model.
        rst_n = 1'b0;
        apply(idle);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cur    = '0;
        last_e = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!(cur.ireq && !last_e.iacc)) begin
                cur.ireq  = ($urandom_range(0, 3) != 0);
                cur.iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (!(cur.dreq && !last_e.dacc)) begin
                cur.dreq   = ($urandom_range(0, 2) == 0);
                cur.daddr  = $urandom;
                cur.dwen   = $urandom_range(0, 1);
                cur.dsize  = 3'($urandom_range(0, 7));
                cur.dwdata = $urandom;
            end
            cur.ready  = ($urandom_range(0, 3) != 0);
            cur.rvalid = (mq.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 499) == 0);
            cur.rdata  = $urandom;
            cur.rerr   = ($urandom_range(0, 15) == 0);
            e = model_eval(cur);
            apply(cur);
            @(negedge clk);
            compare($sformatf("rand%0d", n), e);
            model_commit(cur, e);
            @(posedge clk);
            #1;
            last_e = e;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
